// File: rtl/pixel_compositor_pkg.sv
// pixel_compositor_pkg: shared constants and types for the pixel compositor
package pixel_compositor_pkg;

    localparam int ROM_DEPTH = 86400;
    localparam int ADDR_W    = 17;
    localparam int RGB_W     = 12;

    localparam logic [3:0]       DEF_STAGE1  = 4'd2;
    localparam logic [3:0]       DEF_STAGE2  = 4'd4;
    localparam logic [3:0]       DEF_STAGE3  = 4'd6;
    localparam logic [RGB_W-1:0] DEF_KEY_RGB = 12'hF0F;

    typedef enum logic [1:0] {
        LAYER_BG     = 2'd0,
        LAYER_MAP    = 2'd1,
        LAYER_PLAYER = 2'd2
    } layer_e;

    typedef struct packed {
        logic             valid;
        logic             hs;
        logic             vs;
        layer_e           layer;
        logic [RGB_W-1:0] bg;
    } side_t;

    localparam side_t SIDE_INIT = '{valid: 1'b0, hs: 1'b1, vs: 1'b1, layer: LAYER_BG, bg: '0};

endpackage

// File: rtl/pixel_compositor_if.sv
// pixel_compositor_if: pixel-stream, sprite ROM and VGA pin bundle
interface pixel_compositor_if;
    import pixel_compositor_pkg::*;

    logic [3:0]        state;
    logic              valid;
    logic              hsync_in;
    logic              vsync_in;
    logic              map_obj;
    logic [ADDR_W-1:0] map_addr;
    logic              player_obj;
    logic [ADDR_W-1:0] player_addr;
    logic [ADDR_W-1:0] rom_addr;
    logic [RGB_W-1:0]  rom_data;
    logic [3:0]        vgaRed;
    logic [3:0]        vgaGreen;
    logic [3:0]        vgaBlue;
    logic              hsync;
    logic              vsync;

    modport master (
        output state, valid, hsync_in, vsync_in, map_obj, map_addr, player_obj, player_addr, rom_data,
        input  rom_addr, vgaRed, vgaGreen, vgaBlue, hsync, vsync
    );

    modport slave (
        input  state, valid, hsync_in, vsync_in, map_obj, map_addr, player_obj, player_addr, rom_data,
        output rom_addr, vgaRed, vgaGreen, vgaBlue, hsync, vsync
    );

endinterface

// File: rtl/pixel_compositor_delay_line.sv
// pixel_compositor_delay_line: fixed-depth shift register with reset to a chosen value
module pixel_compositor_delay_line #(
    parameter int               WIDTH = 1,
    parameter int               DEPTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sr [DEPTH];

    // shift one stage per clock, all stages load INIT on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) sr[i] <= INIT;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[DEPTH-1];

endmodule

// File: rtl/pixel_compositor.sv
// pixel_compositor: layer select, ROM latency alignment, colour key and VGA output
module pixel_compositor
    import pixel_compositor_pkg::*;
#(
    parameter int               ROM_LAT  = 1,
    parameter logic [3:0]       STAGE1   = DEF_STAGE1,
    parameter logic [3:0]       STAGE2   = DEF_STAGE2,
    parameter logic [3:0]       STAGE3   = DEF_STAGE3,
    parameter logic [RGB_W-1:0] BG_STAGE = 12'h114,
    parameter logic [RGB_W-1:0] BG_MENU  = 12'h000,
    parameter logic [RGB_W-1:0] KEY_RGB  = DEF_KEY_RGB
) (
    input logic               clk,
    input logic               rst,
    pixel_compositor_if.slave bus
);

    layer_e           layer;
    logic [RGB_W-1:0] bg;
    side_t            side_d;
    side_t            side_q;
    logic [RGB_W-1:0] rgb_d;
    logic [RGB_W-1:0] rgb;
    logic             hs;
    logic             vs;

    // player beats wall; background pixels still present address 0 to the ROM
    always_comb begin
        layer        = bus.player_obj ? LAYER_PLAYER : bus.map_obj ? LAYER_MAP : LAYER_BG;
        bus.rom_addr = bus.player_obj ? bus.player_addr : bus.map_obj ? bus.map_addr : '0;
        bg           = (bus.state == STAGE1 || bus.state == STAGE2 || bus.state == STAGE3) ? BG_STAGE : BG_MENU;
        side_d       = '{valid: bus.valid, hs: bus.hsync_in, vs: bus.vsync_in, layer: layer, bg: bg};
    end

    pixel_compositor_delay_line #(
        .WIDTH ($bits(side_t)),
        .DEPTH (ROM_LAT),
        .INIT  (SIDE_INIT)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .d   (side_d),
        .q   (side_q)
    );

    // blanking overrides everything; a keyed sprite pixel falls straight through to background
    always_comb begin
        rgb_d = !side_q.valid ? '0 :
                (side_q.layer == LAYER_BG || bus.rom_data == KEY_RGB) ? side_q.bg : bus.rom_data;
    end

    // output register keeps colour and syncs on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb <= '0;
            hs  <= 1'b1;
            vs  <= 1'b1;
        end else begin
            rgb <= rgb_d;
            hs  <= side_q.hs;
            vs  <= side_q.vs;
        end
    end

    assign bus.vgaRed   = rgb[11:8];
    assign bus.vgaGreen = rgb[7:4];
    assign bus.vgaBlue  = rgb[3:0];
    assign bus.hsync    = hs;
    assign bus.vsync    = vs;

endmodule

// File: tb/tb_pixel_compositor.sv
// tb_pixel_compositor: three latency variants checked against a per-pixel history model
module tb_pixel_compositor;

    typedef struct packed {
        logic        rst;
        logic [3:0]  state;
        logic        valid;
        logic        hs;
        logic        vs;
        logic        mobj;
        logic [16:0] maddr;
        logic        pobj;
        logic [16:0] paddr;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    rec_t        cur;
    rec_t        hist [2048];
    int          n = 0;
    int          vecs = 0;
    int          errs = 0;
    logic [11:0] rgb_o  [3];
    logic        hs_o   [3];
    logic        vs_o   [3];
    logic [16:0] addr_o [3];

    always #5 clk = ~clk;

    assign rst = cur.rst;

    function automatic logic [11:0] rom_fn(input logic [16:0] a);
        case (a)
            17'd100: return 12'hABC;
            17'd200: return 12'h123;
            17'd300: return 12'hF0F;
            17'd400: return 12'hFFF;
            default: return a[11:0] ^ 12'h5A5;
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : lane
        pixel_compositor_if bus ();
        logic [11:0] q [3];
        assign bus.state       = cur.state;
        assign bus.valid       = cur.valid;
        assign bus.hsync_in    = cur.hs;
        assign bus.vsync_in    = cur.vs;
        assign bus.map_obj     = cur.mobj;
        assign bus.map_addr    = cur.maddr;
        assign bus.player_obj  = cur.pobj;
        assign bus.player_addr = cur.paddr;
        assign bus.rom_data    = q[g];
        assign rgb_o[g]  = {bus.vgaRed, bus.vgaGreen, bus.vgaBlue};
        assign hs_o[g]   = bus.hsync;
        assign vs_o[g]   = bus.vsync;
        assign addr_o[g] = bus.rom_addr;
        always @(posedge clk) begin
            q[0] <= rom_fn(bus.rom_addr);
            q[1] <= q[0];
            q[2] <= q[1];
        end
        pixel_compositor #(.ROM_LAT(g + 1)) dut (
            .clk (clk),
            .rst (rst),
            .bus (bus)
        );
    end

    function automatic rec_t mk(input logic r, input logic [3:0] st, input logic v, input logic h,
                                input logic vv, input logic mo, input logic [16:0] ma,
                                input logic po, input logic [16:0] pa);
        return '{rst: r, state: st, valid: v, hs: h, vs: vv, mobj: mo, maddr: ma, pobj: po, paddr: pa};
    endfunction

    function automatic logic [16:0] exp_addr(input rec_t r);
        return r.pobj ? r.paddr : r.mobj ? r.maddr : 17'd0;
    endfunction

    function automatic logic [11:0] exp_pix(input rec_t r);
        logic [11:0] bg;
        logic [11:0] d;
        bg = (r.state == 4'd2 || r.state == 4'd4 || r.state == 4'd6) ? 12'h114 : 12'h000;
        if (!r.valid) return 12'h000;
        if (!r.pobj && !r.mobj) return bg;
        d = rom_fn(exp_addr(r));
        return (d == 12'hF0F) ? bg : d;
    endfunction

    function automatic logic [13:0] expect_out(input int idx, input int lat);
        for (int k = idx - lat - 1; k < idx; k++)
            if (k < 0 || hist[k].rst) return {12'h000, 2'b11};
        return {exp_pix(hist[idx-lat-1]), hist[idx-lat-1].hs, hist[idx-lat-1].vs};
    endfunction

    task automatic step(input rec_t r);
        logic [13:0] e;
        @(negedge clk);
        cur     = r;
        hist[n] = r;
        #1;
        for (int l = 0; l < 3; l++) begin
            e = expect_out(n, l + 1);
            vecs++;
            assert (addr_o[l] === exp_addr(r)) else begin
                errs++;
                $error("FAIL rom_addr lat%0d n=%0d got %h want %h", l + 1, n, addr_o[l], exp_addr(r));
            end
            vecs++;
            assert (rgb_o[l] === e[13:2]) else begin
                errs++;
                $error("FAIL rgb lat%0d n=%0d got %h want %h", l + 1, n, rgb_o[l], e[13:2]);
            end
            vecs++;
            assert (hs_o[l] === e[1]) else begin
                errs++;
                $error("FAIL hsync lat%0d n=%0d got %b want %b", l + 1, n, hs_o[l], e[1]);
            end
            vecs++;
            assert (vs_o[l] === e[0]) else begin
                errs++;
                $error("FAIL vsync lat%0d n=%0d got %b want %b", l + 1, n, vs_o[l], e[0]);
            end
        end
        n++;
    endtask

    function automatic logic [16:0] rnd_addr();
        case ($urandom_range(0, 5))
            0: return 17'd100;
            1: return 17'd300;
            2: return 17'd400;
            3: return 17'($urandom);
            default: return 17'($urandom_range(0, 86399));
        endcase
    endfunction

    initial begin
        cur = mk(1, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(mk(1, 4'd2, 1, i[0], ~i[0], 1, 200, 1, 100));
        for (int i = 0; i < 5; i++) step(mk(0, 4'd2, 1, 1, 1, 0, 0, 0, 0));
        step(mk(0, 4'd2, 1, 1, 1, 1, 200, 1, 100));
        step(mk(0, 4'd2, 1, 0, 1, 1, 200, 0, 0));
        step(mk(0, 4'd4, 1, 1, 1, 1, 300, 0, 0));
        step(mk(0, 4'd0, 1, 1, 0, 1, 300, 0, 0));
        step(mk(0, 4'd4, 1, 1, 1, 1, 200, 1, 300));
        for (int i = 0; i < 4; i++) step(mk(0, 4'd0, 1, 1, 1, 0, 0, 0, 0));
        for (int i = 0; i < 110; i++) step(mk(0, 4'd2, 0, !(i >= 5 && i < 101), 1, 0, 0, 1, 400));
        for (int i = 0; i < 100; i++) step(mk(0, (i < 50) ? 4'd2 : 4'd0, 1, 1, 1, 0, 0, 0, 0));
        for (int i = 0; i < 700; i++)
            step(mk(($urandom_range(0, 63) == 0), 4'($urandom_range(0, 7)), ($urandom_range(0, 7) != 0),
                    1'($urandom), 1'($urandom), 1'($urandom), rnd_addr(), 1'($urandom), rnd_addr()));
        for (int i = 0; i < 5; i++) step(mk(0, 4'd0, 0, 1, 1, 0, 0, 0, 0));
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
